// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, default store-buffer depth and the buffer entry type
package lsu_pkg;
    localparam int AW = 8;
    localparam int DW = 9;
    localparam int SB_DEPTH_DEFAULT = 4;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: in-order store FIFO with youngest-match address search
//   push/push_entry : enqueue at wptr      pop  : retire head at rptr
//   head            : oldest entry         count: occupied entries
//   lookup_addr     : search key           hit/hit_data: youngest matching entry
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sb_entry_t                push_entry,
    input  logic                     pop,
    input  logic [AW-1:0]            lookup_addr,
    output sb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hit,
    output logic [DW-1:0]            hit_data
);
    localparam int PW = $clog2(DEPTH);
    sb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     wptr, rptr, idx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[wptr] <= 1'b1;
                wptr        <= wptr + 1'b1;
            end
            if (pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= rptr + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) entries[wptr] <= push_entry;
    assign head = entries[rptr];
    // Sweep oldest to youngest so the last match written is the youngest one
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr + PW'(k);
            if (valid[idx] && entries[idx].addr == lookup_addr) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: load/store handshake, store buffering and data-memory port owner
//   req_*   : request handshake from execute (req_we=1 store, 0 load)
//   rsp_*   : load data, one cycle after acceptance
//   sb_empty: store buffer drained
//   mem_*   : single port of the 256x9 data memory (mem_spo combinational read)
// Optional: define SB_FORWARD_EN to forward load data from the store buffer;
// otherwise loads hitting a buffered address stall until it drains.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          sb_empty,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_spo
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(SB_DEPTH);
    logic [PW:0]   count;
    logic          hit, fwd_ok, load_acc, store_acc, drain;
    logic [DW-1:0] hit_data;
    sb_entry_t     head;
`ifdef SB_FORWARD_EN
    assign fwd_ok = 1'b1;
`else
    assign fwd_ok = !hit;
`endif
    // A full buffer stalls loads as well, so the port is left free to drain
    assign req_ready = (count < FULL) && (req_we || fwd_ok);
    assign load_acc  = req_valid && req_ready && !req_we;
    assign store_acc = req_valid && req_ready && req_we;
    assign drain     = !load_acc && count != '0;
    assign sb_empty  = count == '0;
    assign mem_we    = drain;
    assign mem_a     = load_acc ? req_addr : drain ? head.addr : '0;
    assign mem_d     = drain ? head.data : '0;
    lsu_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (store_acc),
        .push_entry  ('{addr: req_addr, data: req_wdata}),
        .pop         (drain),
        .lookup_addr (req_addr),
        .head        (head),
        .count       (count),
        .hit         (hit),
        .hit_data    (hit_data)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= load_acc;
            if (load_acc) rsp_rdata <= hit ? hit_data : mem_spo;
        end
endmodule
